fetch_queue: RTL

- Decoupled instruction-fetch front end. Sits directly upstream of the IF/ID register.
- Generates sequential fetch PCs and issues them to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents the head to decode.
- Honours decode stall (hazard) and branch redirect/flush from EX.

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/fetch_queue.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the decoupled fetch front end.
package fetch_queue_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_BUBBLE       = 32'h0;
  localparam int          PC_STEP          = 4;

  // A FIFO entry carries {pc, instr}.
  function automatic int entry_width(input int xlen);
    return 2 * xlen;
  endfunction

  localparam int DEFAULT_ENTRY_W = 2 * DEFAULT_XLEN;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with single-cycle flush; DEPTH must be a power of two.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               rd_ptr, wr_ptr;
  logic [AW:0]                 cnt;
  logic                        do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch: sequential PC generation, credit-limited imem requests, response FIFO to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_width(XLEN);

  logic [XLEN-1:0] fetch_pc, tail_pc, redirect_base;
  logic [CW-1:0]   outstanding, drop_cnt, occupancy;
  logic [CW:0]     credit_used;
  logic            req_fire, push, pop;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_din, fifo_dout;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

  // Dropped-pending requests still hold credit, so the FIFO can never overflow.
  assign credit_used    = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = reset ? '0 : fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push     = imem_rsp_valid && (drop_cnt == '0) && !redirect;
  assign pop      = if_id_valid && !stall && !redirect;
  assign fifo_din = {tail_pc, imem_rsp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc <= redirect_base;
        tail_pc  <= redirect_base;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (push)     tail_pc  <= tail_pc + XLEN'(PC_STEP);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign if_id_valid = !fifo_empty;
  assign if_id_pc    = if_id_valid ? fifo_dout[EW-1:XLEN] : '0;
  assign if_id_instr = if_id_valid ? fifo_dout[XLEN-1:0]  : XLEN'(NOP_BUBBLE);

  rsp_without_request: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && (outstanding == '0)));

  fifo_never_overflows: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule
